// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio tone sequencer.
package audio_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PRESENT = 2'd2
  } seq_state_t;

  // Per-sample level increment for a sawtooth of wave_rate Hz at sample_rate Hz.
  function automatic longint sawtooth_increment(input int     bit_width,
                                                input longint sample_rate,
                                                input longint wave_rate);
    return (wave_rate * (longint'(1) << bit_width)) / sample_rate;
  endfunction

endpackage

// File: rtl/audio_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module audio_tick_divider #(
  parameter int TICK_DIV = 256
) (
  input  logic clk_audio,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Tick on the terminal count, then wrap to zero.
  always_comb begin
    tick    = (count_q == CW'(TICK_DIV - 1));
    count_d = tick ? '0 : count_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/audio_tone_sequencer.sv
// Time-multiplexed sawtooth generator: one shared adder steps each channel
// once per sample tick, then offers the sample set downstream.
//
// Handshake: sample_valid rises with a complete sample set and sample_word is
// held stable until the cycle where sample_valid && sample_ready; the set is
// consumed on that edge and sample_valid drops in the next cycle.
module audio_tone_sequencer
  import audio_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int TICK_DIV  = 256
) (
  input  logic                                             clk_audio,
  input  logic                                             reset_n,
  input  logic                                             cfg_wr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [BIT_WIDTH-1:0]                             cfg_increment,
  input  logic [CHANNELS-1:0]                              cfg_enable,
  input  logic                                             overrun_clear,
  output logic                                             sample_valid,
  input  logic                                             sample_ready,
  output logic [CHANNELS*BIT_WIDTH-1:0]                    sample_word,
  output logic                                             overrun,
  output logic [1:0]                                       dbg_state
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (TICK_DIV < CHANNELS + 2) begin : g_bad_tick_div
    $error("audio_tone_sequencer: TICK_DIV must be at least CHANNELS+2");
  end

  seq_state_t           state_q;
  logic [CW-1:0]        ch_idx_q;
  logic                 valid_q;
  logic                 overrun_q;
  logic [BIT_WIDTH-1:0] shadow_q [CHANNELS];
  logic [BIT_WIDTH-1:0] active_q [CHANNELS];
  logic [BIT_WIDTH-1:0] level_q  [CHANNELS];
  logic [BIT_WIDTH-1:0] word_q   [CHANNELS];
  logic                 tick;
  logic [BIT_WIDTH-1:0] sum_d;
  logic                 drop_d;

  audio_tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .tick      (tick)
  );

  // Shared adder for the channel being stepped; ticks outside IDLE are lost.
  always_comb begin
    sum_d  = level_q[ch_idx_q] + active_q[ch_idx_q];
    drop_d = tick && (state_q != IDLE);
  end

  // Shadow increments: out-of-range channel indices match no slot.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_wr && (cfg_chan == CW'(i))) shadow_q[i] <= cfg_increment;
      end
    end
  end

  // Sequencer FSM with its datapath registers and sticky overrun.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ch_idx_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        active_q[i] <= '0;
        level_q[i]  <= '0;
        word_q[i]   <= '0;
      end
    end else begin
      // A new drop outranks a simultaneous clear.
      if (drop_d)             overrun_q <= 1'b1;
      else if (overrun_clear) overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < CHANNELS; i++) active_q[i] <= shadow_q[i];
            ch_idx_q <= '0;
            state_q  <= ACCUM;
          end
        end
        ACCUM: begin
          if (cfg_enable[ch_idx_q]) begin
            level_q[ch_idx_q] <= sum_d;
            word_q[ch_idx_q]  <= sum_d;
          end else begin
            word_q[ch_idx_q]  <= '0;
          end
          if (ch_idx_q == CW'(CHANNELS - 1)) begin
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end else begin
            ch_idx_q <= ch_idx_q + CW'(1);
          end
        end
        PRESENT: begin
          if (sample_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign sample_word[g*BIT_WIDTH +: BIT_WIDTH] = word_q[g];
  end

  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Self-checking bench for audio_tone_sequencer (16-bit, 2 channels, TICK_DIV=8).
module tb_audio_tone_sequencer;
  import audio_pkg::*;

  localparam int BW = 16;
  localparam int CH = 2;
  localparam int TD = 8;

  logic             clk_audio;
  logic             reset_n;
  logic             cfg_wr;
  logic [0:0]       cfg_chan;
  logic [BW-1:0]    cfg_increment;
  logic [CH-1:0]    cfg_enable;
  logic             overrun_clear;
  logic             sample_valid;
  logic             sample_ready;
  logic [CH*BW-1:0] sample_word;
  logic             overrun;
  logic [1:0]       dbg_state;

  audio_tone_sequencer #(.BIT_WIDTH(BW), .CHANNELS(CH), .TICK_DIV(TD)) dut (
    .clk_audio     (clk_audio),
    .reset_n       (reset_n),
    .cfg_wr        (cfg_wr),
    .cfg_chan      (cfg_chan),
    .cfg_increment (cfg_increment),
    .cfg_enable    (cfg_enable),
    .overrun_clear (overrun_clear),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sample_word   (sample_word),
    .overrun       (overrun),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_audio = 1'b0;
  always #5 clk_audio = ~clk_audio;

  // ---------------- scoreboard state ----------------
  logic [CH*BW-1:0] exp_q[$];
  int               cyc_q[$];
  logic [CH*BW-1:0] acc_log[$];
  int               n_checks = 0;
  int               n_err    = 0;
  int               n_acc    = 0;
  int               cyc      = 0;
  int               first_valid_cyc = -1;
  logic             prev_valid = 1'b0;

  // Reference model state
  int               m_cnt  = 0;
  logic             m_busy = 1'b0;
  logic             m_ovr  = 1'b0;
  logic [BW-1:0]    m_shadow [CH];
  logic [BW-1:0]    m_level  [CH];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: pushes the expected sample set when a tick is accepted.
  always @(posedge clk_audio or negedge reset_n) begin
    logic             tk;
    logic             set_ovr;
    logic [CH*BW-1:0] w;
    if (!reset_n) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      m_ovr  = 1'b0;
      cyc    = 0;
      first_valid_cyc = -1;
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = '0;
        m_level[i]  = '0;
      end
      exp_q.delete();
      cyc_q.delete();
    end else begin
      tk      = (m_cnt == TD - 1);
      m_cnt   = tk ? 0 : m_cnt + 1;
      set_ovr = 1'b0;
      if (tk) begin
        if (m_busy) set_ovr = 1'b1;
        else begin
          m_busy = 1'b1;
          w = '0;
          for (int i = 0; i < CH; i++) begin
            if (cfg_enable[i]) begin
              m_level[i] = m_level[i] + m_shadow[i];
              w[i*BW +: BW] = m_level[i];
            end
          end
          exp_q.push_back(w);
          cyc_q.push_back(cyc + CH + 1);
        end
      end
      if (sample_valid && sample_ready) m_busy = 1'b0;
      if (set_ovr)            m_ovr = 1'b1;
      else if (overrun_clear) m_ovr = 1'b0;
      if (cfg_wr && (int'(cfg_chan) < CH)) m_shadow[cfg_chan] = cfg_increment;
      cyc++;
    end
  end

  // Monitor: compares outputs mid-cycle and pops on handshake.
  always @(negedge clk_audio) begin
    if (reset_n) begin
      check("overrun", overrun, m_ovr);
      if (sample_valid) begin
        if (!prev_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (cyc_q.size() > 0) check("latency", cyc, cyc_q.pop_front());
        end
        if (exp_q.size() == 0) check("spurious_valid", sample_valid, 1'b0);
        else begin
          check("word", sample_word, exp_q[0]);
          if (sample_ready) begin
            void'(exp_q.pop_front());
            acc_log.push_back(sample_word);
            n_acc++;
          end
        end
      end
      prev_valid = sample_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int chan, input logic [BW-1:0] inc);
    cfg_wr        = 1'b1;
    cfg_chan      = 1'(chan);
    cfg_increment = inc;
    @(posedge clk_audio); #1;
    cfg_wr        = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int budget);
    int target;
    int b;
    target = n_acc + n;
    b      = budget;
    while (n_acc < target && b > 0) begin
      @(posedge clk_audio); #1;
      b--;
    end
    if (n_acc < target) check("sample_timeout", n_acc, target);
  endtask

  task automatic wait_tick_cycle();
    int b;
    b = 4 * TD;
    do begin
      @(posedge clk_audio); #1;
      b--;
    end while (m_cnt != TD - 1 && b > 0);
    if (m_cnt != TD - 1) check("tick_timeout", m_cnt, TD - 1);
  endtask

  task automatic wait_valid(input int budget);
    int b;
    b = budget;
    while (!sample_valid && b > 0) begin
      @(posedge clk_audio); #1;
      b--;
    end
    check("valid_timeout", sample_valid, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int held;
    reset_n       = 1'b0;
    cfg_wr        = 1'b0;
    cfg_chan      = '0;
    cfg_increment = '0;
    cfg_enable    = 2'b11;
    overrun_clear = 1'b0;
    sample_ready  = 1'b1;
    repeat (3) @(posedge clk_audio);
    #1;
    check("rst_valid",   sample_valid, 1'b0);
    check("rst_word",    sample_word,  '0);
    check("rst_overrun", overrun,      1'b0);
    check("rst_state",   dbg_state,    IDLE);
    reset_n = 1'b1;

    // Basic two-channel ramp and first-sample latency.
    cfg_write(0, 16'(sawtooth_increment(16, 48000, 480)));
    cfg_write(1, 16'd1311);
    wait_samples(2, 40);
    check("t1_first_valid_cycle", first_valid_cyc, 10);
    check("t1_sample0", acc_log[0], {16'd1311, 16'd655});
    check("t1_sample1", acc_log[1], {16'd2622, 16'd1310});

    // Config write landing in the tick cycle takes effect one sample later.
    b = acc_log.size();
    wait_tick_cycle();
    cfg_write(0, 16'd100);
    wait_samples(2, 40);
    check("t5_old_inc", 16'(acc_log[b][15:0]   - acc_log[b-1][15:0]), 16'd655);
    check("t5_new_inc", 16'(acc_log[b+1][15:0] - acc_log[b][15:0]),   16'd100);

    // Disabled channel outputs zero and holds its level.
    b    = acc_log.size();
    held = int'(acc_log[b-1][31:16]);
    cfg_enable = 2'b01;
    wait_samples(2, 40);
    check("t4_ch1_off0", acc_log[b][31:16],   16'd0);
    check("t4_ch1_off1", acc_log[b+1][31:16], 16'd0);
    cfg_enable = 2'b11;
    wait_samples(1, 40);
    check("t4_ch1_resume", acc_log[b+2][31:16], 16'(held + 1311));

    // Backpressure: stall 12 cycles, dropped tick raises sticky overrun.
    b = acc_log.size();
    sample_ready = 1'b0;
    wait_valid(40);
    repeat (12) @(posedge clk_audio);
    #1;
    check("t3_stall_valid",   sample_valid, 1'b1);
    check("t3_overrun_set",   overrun,      1'b1);
    sample_ready = 1'b1;
    wait_samples(2, 40);
    check("t3_one_step_ch0", 16'(acc_log[b+1][15:0]  - acc_log[b][15:0]),  16'd100);
    check("t3_one_step_ch1", 16'(acc_log[b+1][31:16] - acc_log[b][31:16]), 16'd1311);
    overrun_clear = 1'b1;
    @(posedge clk_audio); #1;
    overrun_clear = 1'b0;
    check("t3_overrun_cleared", overrun, 1'b0);

    // Reset in the middle of accumulation.
    wait_tick_cycle();
    @(posedge clk_audio); #1;
    check("t6_in_accum", dbg_state, ACCUM);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", sample_valid, 1'b0);
    check("t6_rst_word",  sample_word,  '0);
    check("t6_rst_state", dbg_state,    IDLE);
    @(posedge clk_audio); #1;
    reset_n = 1'b1;
    wait_samples(1, 40);
    check("t6_zero_sample", acc_log[acc_log.size()-1], '0);

    // Wrap-around without saturation.
    b = acc_log.size();
    cfg_write(0, 16'h4000);
    wait_samples(4, 80);
    check("t2_wrap0", acc_log[b][15:0],   16'h4000);
    check("t2_wrap1", acc_log[b+1][15:0], 16'h8000);
    check("t2_wrap2", acc_log[b+2][15:0], 16'hC000);
    check("t2_wrap3", acc_log[b+3][15:0], 16'h0000);

    // Random backpressure, config writes and overrun clears.
    for (int i = 0; i < 400; i++) begin
      sample_ready  = ($urandom_range(0, 3) != 0);
      overrun_clear = ($urandom_range(0, 15) == 0);
      cfg_wr        = ($urandom_range(0, 7) == 0);
      cfg_chan      = 1'($urandom_range(0, 1));
      cfg_increment = 16'($urandom_range(0, 65535));
      @(posedge clk_audio); #1;
    end
    cfg_wr        = 1'b0;
    overrun_clear = 1'b0;
    sample_ready  = 1'b1;
    b = 8 * TD;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk_audio); #1;
      b--;
    end
    check("drain", exp_q.size(), 0);
    check("min_samples", (n_acc > 20), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
